// File: rtl/i2s_rx_frontend.sv
// i2s_rx_frontend: oversampled I2S receiver that delivers signed left/right sample pairs
// and a one-clk audio_rx_down strobe to the ANC sample pipeline.
`default_nettype none

module i2s_rx_frontend #(
  parameter int DATA_WIDTH   = 16,
  parameter int SYNC_STAGES  = 2,
  parameter int BCLK_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i2s_bclk,
  input  logic                  i2s_lrck,
  input  logic                  i2s_adcdat,
  output logic [DATA_WIDTH-1:0] audio_left_o,
  output logic [DATA_WIDTH-1:0] audio_right_o,
  output logic                  audio_rx_down,
  output logic                  frame_err,
  output logic                  link_ok
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 2);
  localparam int TO_W  = $clog2(BCLK_TIMEOUT + 1);

  localparam logic [CNT_W-1:0] C_DATA_BITS = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0] C_BIT_SAT   = CNT_W'(DATA_WIDTH + 1);
  localparam logic [TO_W-1:0]  C_TIMEOUT   = TO_W'(BCLK_TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LEFT  = 2'd1,
    S_RIGHT = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] r_bclk_sync;
  logic [SYNC_STAGES-1:0] r_lrck_sync;
  logic [SYNC_STAGES-1:0] r_dat_sync;
  logic                   r_bclk_prev;
  logic                   r_lrck_last;
  logic [CNT_W-1:0]       r_bit_cnt;
  logic [DATA_WIDTH-1:0]  r_shift;
  logic [DATA_WIDTH-1:0]  r_left_hold;
  logic [TO_W-1:0]        r_to_cnt;
  state_t                 r_state;
  state_t                 w_next;

  logic [DATA_WIDTH-1:0]  r_left;
  logic [DATA_WIDTH-1:0]  r_right;
  logic                   r_rx_down;
  logic                   r_ferr;
  logic                   r_link;

  logic w_bclk_s;
  logic w_lrck_s;
  logic w_dat_s;
  logic w_rise;
  logic w_boundary;
  logic w_slot_valid;
  logic w_timeout;
  logic w_strobe;
  logic w_ferr;
  logic w_latch_left;
  logic w_link_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bclk_sync <= '0;
      r_lrck_sync <= '0;
      r_dat_sync  <= '0;
      r_bclk_prev <= 1'b0;
    end else begin
      r_bclk_sync <= {r_bclk_sync[SYNC_STAGES-2:0], i2s_bclk};
      r_lrck_sync <= {r_lrck_sync[SYNC_STAGES-2:0], i2s_lrck};
      r_dat_sync  <= {r_dat_sync[SYNC_STAGES-2:0], i2s_adcdat};
      r_bclk_prev <= w_bclk_s;
    end
  end

  assign w_bclk_s     = r_bclk_sync[SYNC_STAGES-1];
  assign w_lrck_s     = r_lrck_sync[SYNC_STAGES-1];
  assign w_dat_s      = r_dat_sync[SYNC_STAGES-1];
  assign w_rise       = w_bclk_s & ~r_bclk_prev;
  assign w_boundary   = w_rise & (w_lrck_s != r_lrck_last);
  assign w_slot_valid = (r_bit_cnt >= C_DATA_BITS);
  // A rise in the same cycle restarts the count, so it cannot also time out.
  assign w_timeout    = (r_to_cnt == C_TIMEOUT) & ~w_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_strobe     = 1'b0;
    w_ferr       = 1'b0;
    w_latch_left = 1'b0;
    w_link_clr   = 1'b0;
    if (w_timeout) begin
      w_next     = S_IDLE;
      w_link_clr = 1'b1;
    end else if (w_boundary) begin
      case (r_state)
        S_IDLE: begin
          if (!w_lrck_s) w_next = S_LEFT;
        end
        S_LEFT: begin
          if (w_lrck_s) begin
            if (w_slot_valid) begin
              w_latch_left = 1'b1;
              w_next       = S_RIGHT;
            end else begin
              w_ferr = 1'b1;
              w_next = S_IDLE;
            end
          end
        end
        S_RIGHT: begin
          if (!w_lrck_s) begin
            if (w_slot_valid) begin
              w_strobe = 1'b1;
              w_next   = S_LEFT;
            end else begin
              w_ferr = 1'b1;
              w_next = S_IDLE;
            end
          end
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  // The boundary bit is the I2S delay slot: it restarts the count and is never shifted in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lrck_last <= 1'b0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_to_cnt    <= '0;
    end else begin
      if (w_rise) begin
        r_lrck_last <= w_lrck_s;
        r_to_cnt    <= '0;
      end else if (r_to_cnt != C_TIMEOUT) begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end

      if (w_boundary) begin
        r_bit_cnt <= '0;
      end else if (w_rise) begin
        if (r_bit_cnt < C_BIT_SAT) r_bit_cnt <= r_bit_cnt + CNT_W'(1);
        if (r_bit_cnt < C_DATA_BITS) r_shift <= {r_shift[DATA_WIDTH-2:0], w_dat_s};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_left_hold <= '0;
      r_left      <= '0;
      r_right     <= '0;
      r_rx_down   <= 1'b0;
      r_ferr      <= 1'b0;
      r_link      <= 1'b0;
    end else begin
      if (w_latch_left) r_left_hold <= r_shift;
      if (w_strobe) begin
        r_left  <= r_left_hold;
        r_right <= r_shift;
      end
      r_rx_down <= w_strobe;
      r_ferr    <= w_ferr;
      if (w_strobe) begin
        r_link <= 1'b1;
      end else if (w_ferr || w_link_clr) begin
        r_link <= 1'b0;
      end
    end
  end

  assign audio_left_o  = r_left;
  assign audio_right_o = r_right;
  assign audio_rx_down = r_rx_down;
  assign frame_err     = r_ferr;
  assign link_ok       = r_link;

endmodule

`default_nettype wire

// File: tb/tb_i2s_rx_frontend.sv
// tb_i2s_rx_frontend: directed I2S frames with hand-computed sample pairs and strobe timing.
`default_nettype none

module tb_i2s_rx_frontend;

  localparam int DW = 16;
  localparam int HB = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          bclk = 1'b0;
  logic          lrck = 1'b0;
  logic          dat = 1'b0;
  logic [DW-1:0] left_o;
  logic [DW-1:0] right_o;
  logic          rx_down;
  logic          ferr;
  logic          link;

  int pass_cnt = 0;
  int check_cnt = 0;

  int cyc = 0;
  int left_edge_cyc = 0;
  int last_rise_cyc = 0;
  int link_fall_cyc = -1;
  int strobe_cnt = 0;
  int ferr_cnt = 0;
  bit both_high = 1'b0;
  bit wide_pulse = 1'b0;
  logic prev_rx = 1'b0;
  logic prev_ferr = 1'b0;
  logic prev_link = 1'b0;
  logic [DW-1:0] s_left [0:63];
  logic [DW-1:0] s_right [0:63];
  int s_lat [0:63];

  i2s_rx_frontend #(
    .DATA_WIDTH  (16),
    .SYNC_STAGES (2),
    .BCLK_TIMEOUT(255)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i2s_bclk     (bclk),
    .i2s_lrck     (lrck),
    .i2s_adcdat   (dat),
    .audio_left_o (left_o),
    .audio_right_o(right_o),
    .audio_rx_down(rx_down),
    .frame_err    (ferr),
    .link_ok      (link)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_down) begin
      if (strobe_cnt < 64) begin
        s_left[strobe_cnt]  = left_o;
        s_right[strobe_cnt] = right_o;
        s_lat[strobe_cnt]   = cyc - left_edge_cyc;
      end
      strobe_cnt = strobe_cnt + 1;
    end
    if (ferr) ferr_cnt = ferr_cnt + 1;
    if (rx_down && ferr) both_high = 1'b1;
    if ((rx_down && prev_rx) || (ferr && prev_ferr)) wide_pulse = 1'b1;
    if (prev_link && !link) link_fall_cyc = cyc;
    prev_rx   = rx_down;
    prev_ferr = ferr;
    prev_link = link;
  end

  // One BCLK period = 16 clk; the rising edge is placed mid-bit.
  task automatic send_bit(input logic lr, input logic d, input bit first_left);
    bclk = 1'b0;
    lrck = lr;
    dat  = d;
    repeat (HB) @(negedge clk);
    bclk = 1'b1;
    last_rise_cyc = cyc;
    if (first_left) left_edge_cyc = cyc;
    repeat (HB) @(negedge clk);
  endtask

  task automatic send_slot(input logic lr, input logic [DW-1:0] val, input int nbits,
                           input logic pad);
    logic d;
    for (int i = 0; i < nbits; i++) begin
      d = (i >= 1 && i <= DW) ? val[DW-i] : pad;
      send_bit(lr, d, (lr == 1'b0) && (i == 0));
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input int rbits,
                            input logic pad);
    send_slot(1'b0, l, 32, pad);
    send_slot(1'b1, r, rbits, pad);
  endtask

  task automatic test_reset();
    repeat (4) @(negedge clk);
    check_cnt++; if (left_o !== 16'h0000) $display("FAIL reset_left got=%h exp=0000", left_o); else pass_cnt++;
    check_cnt++; if (right_o !== 16'h0000) $display("FAIL reset_right got=%h exp=0000", right_o); else pass_cnt++;
    check_cnt++; if (rx_down !== 1'b0) $display("FAIL reset_rx_down got=%b exp=0", rx_down); else pass_cnt++;
    check_cnt++; if (ferr !== 1'b0) $display("FAIL reset_frame_err got=%b exp=0", ferr); else pass_cnt++;
    check_cnt++; if (link !== 1'b0) $display("FAIL reset_link_ok got=%b exp=0", link); else pass_cnt++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_nominal();
    int base;
    base = strobe_cnt;
    send_frame(16'h8001, 16'h7FFE, 32, 1'b0);
    send_frame(16'h8001, 16'h7FFE, 32, 1'b0);
    check_cnt++; if (strobe_cnt !== base) $display("FAIL nominal_no_early_strobe got=%0d exp=%0d", strobe_cnt, base); else pass_cnt++;
    send_frame(16'h0000, 16'hFFFF, 32, 1'b0);
    check_cnt++; if (strobe_cnt !== base + 1) $display("FAIL nominal_strobe_count got=%0d exp=%0d", strobe_cnt, base + 1); else pass_cnt++;
    check_cnt++; if (s_left[base] !== 16'h8001) $display("FAIL nominal_left got=%h exp=8001", s_left[base]); else pass_cnt++;
    check_cnt++; if (s_right[base] !== 16'h7FFE) $display("FAIL nominal_right got=%h exp=7ffe", s_right[base]); else pass_cnt++;
    check_cnt++; if (s_lat[base] !== 3) $display("FAIL nominal_latency got=%0d exp=3", s_lat[base]); else pass_cnt++;
    check_cnt++; if (left_o !== 16'h8001 || right_o !== 16'h7FFE) $display("FAIL nominal_hold got=%h/%h exp=8001/7ffe", left_o, right_o); else pass_cnt++;
    check_cnt++; if (link !== 1'b1) $display("FAIL nominal_link got=%b exp=1", link); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_l [0:3];
    int base;
    int fall0;
    exp_l[0] = 16'h0000; exp_l[1] = 16'hFFFF; exp_l[2] = 16'h1234; exp_l[3] = 16'hA5A5;
    base  = strobe_cnt;
    fall0 = link_fall_cyc;
    for (int k = 1; k < 4; k++) send_frame(exp_l[k], ~exp_l[k], 32, 1'b0);
    send_frame(16'h0F0F, 16'hF0F0, 32, 1'b0);
    check_cnt++; if (strobe_cnt !== base + 4) $display("FAIL b2b_count got=%0d exp=%0d", strobe_cnt - base, 4); else pass_cnt++;
    for (int k = 0; k < 4; k++) begin
      check_cnt++;
      if (s_left[base+k] !== exp_l[k] || s_right[base+k] !== ~exp_l[k] || s_lat[base+k] !== 3)
        $display("FAIL b2b_pair%0d got=%h/%h lat=%0d exp=%h/%h lat=3", k, s_left[base+k],
                 s_right[base+k], s_lat[base+k], exp_l[k], ~exp_l[k]);
      else pass_cnt++;
    end
    check_cnt++; if (link !== 1'b1 || link_fall_cyc !== fall0) $display("FAIL b2b_link got=%b fall=%0d exp=1 fall=%0d", link, link_fall_cyc, fall0); else pass_cnt++;
    check_cnt++; if (wide_pulse !== 1'b0) $display("FAIL b2b_pulse_width got=%b exp=0", wide_pulse); else pass_cnt++;
  endtask

  task automatic test_short_slot();
    int base;
    int fb;
    base = strobe_cnt;
    fb   = ferr_cnt;
    send_frame(16'h1111, 16'h2222, 12, 1'b0);
    send_frame(16'h3333, 16'h4444, 32, 1'b0);
    check_cnt++; if (ferr_cnt !== fb + 1) $display("FAIL short_frame_err got=%0d exp=%0d", ferr_cnt - fb, 1); else pass_cnt++;
    check_cnt++; if (strobe_cnt !== base + 1) $display("FAIL short_no_strobe got=%0d exp=%0d", strobe_cnt - base, 1); else pass_cnt++;
    check_cnt++; if (left_o !== 16'h0F0F || right_o !== 16'hF0F0) $display("FAIL short_hold got=%h/%h exp=0f0f/f0f0", left_o, right_o); else pass_cnt++;
    check_cnt++; if (link !== 1'b0) $display("FAIL short_link got=%b exp=0", link); else pass_cnt++;
    send_frame(16'h5555, 16'hAAAA, 32, 1'b0);
    send_frame(16'h6666, 16'h9999, 32, 1'b0);
    check_cnt++; if (strobe_cnt !== base + 2) $display("FAIL short_recover_count got=%0d exp=%0d", strobe_cnt - base, 2); else pass_cnt++;
    check_cnt++; if (s_left[base+1] !== 16'h5555 || s_right[base+1] !== 16'hAAAA) $display("FAIL short_recover_pair got=%h/%h exp=5555/aaaa", s_left[base+1], s_right[base+1]); else pass_cnt++;
    check_cnt++; if (link !== 1'b1 || both_high !== 1'b0) $display("FAIL short_recover_link got=%b both=%b exp=1 both=0", link, both_high); else pass_cnt++;
  endtask

  task automatic test_timeout();
    int base;
    int dt;
    base = strobe_cnt;
    repeat (100) @(negedge clk);
    check_cnt++; if (link !== 1'b1) $display("FAIL timeout_early got=%b exp=1", link); else pass_cnt++;
    repeat (200) @(negedge clk);
    dt = link_fall_cyc - last_rise_cyc;
    check_cnt++; if (link !== 1'b0) $display("FAIL timeout_link got=%b exp=0", link); else pass_cnt++;
    check_cnt++; if (dt < 255 || dt > 262) $display("FAIL timeout_cycle got=%0d exp=255..262", dt); else pass_cnt++;
    check_cnt++; if (left_o !== 16'h5555 || right_o !== 16'hAAAA || strobe_cnt !== base) $display("FAIL timeout_hold got=%h/%h n=%0d exp=5555/aaaa n=%0d", left_o, right_o, strobe_cnt, base); else pass_cnt++;
    send_frame(16'h1357, 16'h2468, 32, 1'b0);
    check_cnt++; if (strobe_cnt !== base) $display("FAIL timeout_no_strobe got=%0d exp=%0d", strobe_cnt, base); else pass_cnt++;
    send_frame(16'hABCD, 16'h4321, 32, 1'b0);
    check_cnt++; if (strobe_cnt !== base + 1 || s_left[base] !== 16'h1357 || s_right[base] !== 16'h2468) $display("FAIL timeout_resume got=%h/%h n=%0d exp=1357/2468 n=%0d", s_left[base], s_right[base], strobe_cnt, base + 1); else pass_cnt++;
    check_cnt++; if (link !== 1'b1) $display("FAIL timeout_relock got=%b exp=1", link); else pass_cnt++;
  endtask

  task automatic test_reset_midframe();
    int base;
    send_slot(1'b0, 16'hBEEF, 10, 1'b0);
    check_cnt++; if (left_o !== 16'hABCD || right_o !== 16'h4321) $display("FAIL midrst_before got=%h/%h exp=abcd/4321", left_o, right_o); else pass_cnt++;
    #3 rst_n = 1'b0;
    #1;
    check_cnt++; if (left_o !== 16'h0000 || right_o !== 16'h0000 || link !== 1'b0) $display("FAIL midrst_async got=%h/%h link=%b exp=0000/0000 link=0", left_o, right_o, link); else pass_cnt++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base = strobe_cnt;
    send_slot(1'b0, 16'h0000, 22, 1'b0);
    send_slot(1'b1, 16'h0000, 32, 1'b0);
    send_frame(16'h0000, 16'h0000, 32, 1'b1);
    check_cnt++; if (strobe_cnt !== base) $display("FAIL midrst_no_strobe got=%0d exp=%0d", strobe_cnt - base, 0); else pass_cnt++;
    send_frame(16'h0000, 16'h0000, 32, 1'b1);
    check_cnt++; if (strobe_cnt !== base + 1) $display("FAIL midrst_strobe got=%0d exp=%0d", strobe_cnt - base, 1); else pass_cnt++;
    check_cnt++; if (s_left[base] !== 16'h0000 || s_right[base] !== 16'h0000) $display("FAIL midrst_delay_bit got=%h/%h exp=0000/0000", s_left[base], s_right[base]); else pass_cnt++;
    check_cnt++; if (link !== 1'b1 || both_high !== 1'b0 || wide_pulse !== 1'b0) $display("FAIL midrst_final got=link%b both%b wide%b exp=link1 both0 wide0", link, both_high, wide_pulse); else pass_cnt++;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_nominal();
    test_back_to_back();
    test_short_slot();
    test_timeout();
    test_reset_midframe();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/i2s_rx_frontend.md
Name: i2s_rx_frontend

Overview:
- Upstream feeder of the ANC core: deserialises the codec ADC I2S stream into signed 16-bit left (reference mic, xn) and right (error mic, en) samples.
- Issues the one-cycle audio_rx_down strobe that advances the ANC sample pipeline.
- Runs in the ANC system clock domain: oversamples BCLK/LRCK/ADCDAT through synchronisers, with no separate bit-clock domain.

Parameters:
- DATA_WIDTH, 16, sample width captured per channel (MSB first).
- SYNC_STAGES, 2, flip-flop stages on each I2S input (minimum 2).
- BCLK_TIMEOUT, 255, clk cycles without a BCLK rising edge before the link is declared lost.

Ports:
- clk  input  1  system clock; must be ≥4x BCLK.
- rst_n  input  1  asynchronous active-low reset.
- i2s_bclk  input  1  codec bit clock, asynchronous.
- i2s_lrck  input  1  codec word select; 0 = left, 1 = right.
- i2s_adcdat  input  1  codec serial ADC data.
- audio_left_o  output  DATA_WIDTH  signed left sample (xn), held between strobes.
- audio_right_o  output  DATA_WIDTH  signed right sample (en), held between strobes.
- audio_rx_down  output  1  one-clk pulse when a new left/right pair is valid.
- frame_err  output  1  one-clk pulse when a short slot is detected.
- link_ok  output  1  high while frames are locked.

Behaviour:
- Reset: all outputs 0; state IDLE; shift register and counters 0.
- Synchronisers: each I2S input passes through SYNC_STAGES flip-flops. A BCLK rise event is a cycle where the synced bclk is 1 and its previous value was 0.
- Sampling: on each BCLK rise event, sample the synced lrck and adcdat. All further logic advances only on these events.
- Slot boundary: a rise event whose sampled lrck differs from the lrck sampled at the previous rise event.
  - That bit is the I2S one-bit delay slot and is discarded.
  - bit_cnt is reset to 0.
- In-slot bits: bit_cnt increments, saturating at DATA_WIDTH+1. While bit_cnt < DATA_WIDTH, data shifts in MSB first; later bits are ignored.
- Slot completion: a completed slot is valid iff it captured DATA_WIDTH bits. A valid slot needs ≥ DATA_WIDTH+1 BCLKs including the delay bit.
- State machine:
  - IDLE: ignore data. A falling lrck boundary → LEFT. Other boundaries stay in IDLE. link_ok = 0.
  - LEFT: a rising boundary ends the left slot.
    - Valid: latch the shift register into left_hold, → RIGHT.
    - Short: pulse frame_err, → IDLE.
  - RIGHT: a falling boundary ends the right slot.
    - Valid: update audio_left_o ← left_hold and audio_right_o ← shift register in the same clk edge; pulse audio_rx_down; set link_ok = 1; → LEFT.
    - Short: pulse frame_err, no strobe, → IDLE.
  - A boundary of unexpected polarity cannot occur with sampled lrck; no handling is required.
- Latency: audio_rx_down and the output update occur exactly 1 clk after the clk cycle in which the falling-boundary rise event is detected. Outputs change only on that edge.
- First frame after reset or relock: the partial frame is discarded. The first strobe follows the first complete LEFT+RIGHT pair.
- Timeout: a counter counts clk cycles since the last rise event. Reaching BCLK_TIMEOUT forces IDLE and link_ok = 0; the counter saturates. Held outputs keep their last values; no strobe is issued.
- audio_rx_down and frame_err are never high together. Each is high for at most 1 clk per frame.
- Asynchronous reset mid-frame: immediate return to reset values. The next strobe occurs only after a full new frame.

Test Plan:
- Nominal: 64 BCLK/frame (32-bit slots), clk = 16x BCLK, left = 0x8001, right = 0x7FFE → audio_left_o = 0x8001 and audio_right_o = 0x7FFE, set together on a single 1-clk audio_rx_down pulse. The first partial frame after reset produces no strobe.
- Back-to-back: 4 frames with left = 0x0000, 0xFFFF, 0x1234, 0xA5A5 and right = ~left → exactly 4 strobes, each exactly 1 clk after the falling-boundary detect, values in order, link_ok stays 1.
- Short slot: right slot of 12 BCLKs → frame_err pulse, no audio_rx_down, outputs hold the previous pair, link_ok = 0. The next clean frame pair restores the strobe and link_ok = 1.
- Timeout: stop BCLK for 300 clk → link_ok falls at cycle 255 and the outputs hold. Resuming BCLK gives the first strobe after a full LEFT+RIGHT pair.
- Reset mid-frame: assert rst_n low during the left slot → outputs 0 immediately. After release, no strobe until one full frame completes. The bit following each LRCK edge is never captured: set it to 1 with data 0x0000 → output 0x0000.
